// File: rtl/riscv_hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// The ID stage (master) presents the decoded instruction and reads back
// the stall/accept decision plus the scoreboard occupancy.
interface riscv_hazard_scoreboard_if #(
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_WIDTH    = 32
);
  localparam int NUM_REGS = 2 ** REG_ADDR_LEN;

  logic                    issue_valid;
  logic [REG_ADDR_LEN-1:0] issue_rd;
  logic                    issue_reg_write;
  logic                    issue_is_load;
  logic [REG_ADDR_LEN-1:0] issue_rs1;
  logic [1:0]              issue_rs1_use;
  logic [REG_ADDR_LEN-1:0] issue_rs2;
  logic [1:0]              issue_rs2_use;
  logic                    flush;
  logic                    stall;
  logic                    accept;
  logic [NUM_REGS-1:0]     busy;
  logic [CNT_WIDTH-1:0]    stall_count;

  modport master (
    output issue_valid, issue_rd, issue_reg_write, issue_is_load,
           issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use, flush,
    input  stall, accept, busy, stall_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_reg_write, issue_is_load,
           issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use, flush,
    output stall, accept, busy, stall_count
  );
endinterface

// File: rtl/riscv_hazard_scoreboard.sv
// Per-register countdown scoreboard for the ID stage. Each in-flight
// result carries a count of cycles until it reaches the forwarding
// network; an operand stalls while that count is at least the stage
// number in which the consumer actually reads it (1 ID, 2 EX, 3 MEM).
module riscv_hazard_scoreboard #(
  parameter int REG_ADDR_LEN = 5,
  parameter int LAT_WIDTH    = 3,
  parameter int ALU_LAT      = 1,
  parameter int LOAD_LAT     = 2,
  parameter int CNT_WIDTH    = 32
) (
  input logic                     clk,
  input logic                     rst,
  riscv_hazard_scoreboard_if.slave sb
);
  localparam int NUM_REGS = 2 ** REG_ADDR_LEN;

  // x0 owns no storage: entry 0 of cnt_q is never declared
  logic [LAT_WIDTH-1:0] cnt_q [1:NUM_REGS-1];
  logic [LAT_WIDTH-1:0] cnt_d [1:NUM_REGS-1];
  logic [LAT_WIDTH-1:0] cntView [NUM_REGS];
  logic [CNT_WIDTH-1:0] stallCount_q;
  logic [CNT_WIDTH-1:0] stallCount_d;
  logic [NUM_REGS-1:0]  busyVec;
  logic                 haz1;
  logic                 haz2;
  logic                 live;
  logic                 stallInt;
  logic                 acceptInt;
  logic                 writeEn;

  // Full-width read view of the counters with x0 hard-wired to zero
  always_comb begin
    cntView[0] = '0;
    busyVec[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cntView[r] = cnt_q[r];
      busyVec[r] = (cnt_q[r] != '0);
    end
  end

  // Operand hazards against pre-update counts, plus the stall/accept decision
  always_comb begin
    haz1 = (sb.issue_rs1_use != 2'd0) && (sb.issue_rs1 != '0) &&
           (int'(cntView[sb.issue_rs1]) >= int'(sb.issue_rs1_use));
    haz2 = (sb.issue_rs2_use != 2'd0) && (sb.issue_rs2 != '0) &&
           (int'(cntView[sb.issue_rs2]) >= int'(sb.issue_rs2_use));
    live      = !rst && sb.issue_valid && !sb.flush;
    stallInt  = live && (haz1 || haz2);
    acceptInt = live && !stallInt;
    writeEn   = acceptInt && sb.issue_reg_write && (sb.issue_rd != '0);
  end

  // Next counts: everything ages by one, an accepted producer reloads its rd
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_WIDTH'(1)) : '0;
      if (writeEn && (sb.issue_rd == REG_ADDR_LEN'(r))) begin
        cnt_d[r] = sb.issue_is_load ? LAT_WIDTH'(LOAD_LAT) : LAT_WIDTH'(ALU_LAT);
      end
    end
    stallCount_d = stallCount_q;
    if (stallInt && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + CNT_WIDTH'(1);
    end
  end

  // Scoreboard and performance counter state with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stallCount_q <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stallCount_q <= stallCount_d;
    end
  end

  // Drive the interface outputs
  always_comb begin
    sb.stall       = stallInt;
    sb.accept      = acceptInt;
    sb.busy        = busyVec;
    sb.stall_count = stallCount_q;
  end
endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for the hazard scoreboard. Three instances share one
// stimulus stream: default latencies, LOAD_LAT=3 and LOAD_LAT=7.
module tb_riscv_hazard_scoreboard;
  logic       clk;
  logic       rst;
  logic       valid;
  logic [4:0] rd;
  logic       regWrite;
  logic       isLoad;
  logic [4:0] rs1;
  logic [1:0] use1;
  logic [4:0] rs2;
  logic [1:0] use2;
  logic       flush;
  int         errors;
  int         checks;

  riscv_hazard_scoreboard_if #(.REG_ADDR_LEN(5), .CNT_WIDTH(32)) ifA ();
  riscv_hazard_scoreboard_if #(.REG_ADDR_LEN(5), .CNT_WIDTH(32)) ifB ();
  riscv_hazard_scoreboard_if #(.REG_ADDR_LEN(5), .CNT_WIDTH(32)) ifC ();

  riscv_hazard_scoreboard dutA (.clk(clk), .rst(rst), .sb(ifA));
  riscv_hazard_scoreboard #(.LOAD_LAT(3)) dutB (.clk(clk), .rst(rst), .sb(ifB));
  riscv_hazard_scoreboard #(.LAT_WIDTH(3), .LOAD_LAT(7)) dutC (.clk(clk), .rst(rst), .sb(ifC));

  // Fan the shared stimulus out to all three instances
  always_comb begin
    ifA.issue_valid = valid; ifA.issue_rd = rd; ifA.issue_reg_write = regWrite;
    ifA.issue_is_load = isLoad; ifA.issue_rs1 = rs1; ifA.issue_rs1_use = use1;
    ifA.issue_rs2 = rs2; ifA.issue_rs2_use = use2; ifA.flush = flush;
    ifB.issue_valid = valid; ifB.issue_rd = rd; ifB.issue_reg_write = regWrite;
    ifB.issue_is_load = isLoad; ifB.issue_rs1 = rs1; ifB.issue_rs1_use = use1;
    ifB.issue_rs2 = rs2; ifB.issue_rs2_use = use2; ifB.flush = flush;
    ifC.issue_valid = valid; ifC.issue_rd = rd; ifC.issue_reg_write = regWrite;
    ifC.issue_is_load = isLoad; ifC.issue_rs1 = rs1; ifC.issue_rs1_use = use1;
    ifC.issue_rs2 = rs2; ifC.issue_rs2_use = use2; ifC.flush = flush;
  end

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction slot at the falling edge, then let it settle
  task automatic applyStimulus(input logic v, input logic [4:0] d, input logic w,
                               input logic ld, input logic [4:0] s1, input logic [1:0] u1,
                               input logic [4:0] s2, input logic [1:0] u2, input logic fl);
    @(negedge clk);
    valid = v; rd = d; regWrite = w; isLoad = ld;
    rs1 = s1; use1 = u1; rs2 = s2; use2 = u2; flush = fl;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    idleCycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    idleCycle();
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 2'd2, 5'd2, 2'd2, 1'b0);
    checkOutput("rst_stall", 64'(ifA.stall), 64'd0);
    checkOutput("rst_accept", 64'(ifA.accept), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    idleCycle();
    checkOutput("reset_busy", 64'(ifA.busy), 64'd0);
    checkOutput("reset_stall_count", 64'(ifA.stall_count), 64'd0);

    // add x5 then sub x6,x5,x5 : ALU result forwards to EX, no stall
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 2'd2, 5'd2, 2'd2, 1'b0);
    checkOutput("alu_prod_accept", 64'(ifA.accept), 64'd1);
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 2'd2, 5'd5, 2'd2, 1'b0);
    checkOutput("alu_cons_stall", 64'(ifA.stall), 64'd0);
    checkOutput("alu_cons_accept", 64'(ifA.accept), 64'd1);
    checkOutput("alu_busy5_set", 64'(ifA.busy), 64'h20);
    idleCycle();
    checkOutput("alu_busy5_gone", 64'(ifA.busy), 64'h40);
    idleCycle();
    checkOutput("alu_busy_clear", 64'(ifA.busy), 64'd0);

    // lw x5 then add x7,x5,x1 : one load-use bubble
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd2, 2'd2, 5'd0, 2'd0, 1'b0);
    checkOutput("lu_load_accept", 64'(ifA.accept), 64'd1);
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 5'd5, 2'd2, 5'd1, 2'd2, 1'b0);
    checkOutput("lu_stall1", 64'(ifA.stall), 64'd1);
    checkOutput("lu_accept1", 64'(ifA.accept), 64'd0);
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 5'd5, 2'd2, 5'd1, 2'd2, 1'b0);
    checkOutput("lu_stall2", 64'(ifA.stall), 64'd0);
    checkOutput("lu_accept2", 64'(ifA.accept), 64'd1);
    checkOutput("lu_stall_count", 64'(ifA.stall_count), 64'd1);
    idleCycle();
    idleCycle();

    // lw x5 then beq x5,x0 : two bubbles; add x5 then beq : one bubble
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 5'd0, 2'd1, 1'b0);
      checkOutput($sformatf("lb_stall%0d", i), 64'(ifA.stall), 64'd1);
    end
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 5'd0, 2'd1, 1'b0);
    checkOutput("lb_accept", 64'(ifA.accept), 64'd1);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 5'd0, 2'd1, 1'b0);
    checkOutput("ab_stall", 64'(ifA.stall), 64'd1);
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 5'd0, 2'd1, 1'b0);
    checkOutput("ab_accept", 64'(ifA.accept), 64'd1);
    idleCycle();
    checkOutput("branch_stall_count", 64'(ifA.stall_count), 64'd4);

    // lw x5 then sw x5,0(x2) : store data read in MEM
    resetCycle();
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 2'd2, 5'd5, 2'd3, 1'b0);
    checkOutput("ls_lat2_stall", 64'(ifA.stall), 64'd0);
    checkOutput("ls_lat2_accept", 64'(ifA.accept), 64'd1);
    checkOutput("ls_lat3_stall", 64'(ifB.stall), 64'd1);
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 2'd2, 5'd5, 2'd3, 1'b0);
    checkOutput("ls_lat3_accept", 64'(ifB.accept), 64'd1);
    idleCycle();
    checkOutput("ls_lat3_stall_count", 64'(ifB.stall_count), 64'd1);

    // x0 never becomes busy; a flushed consumer neither stalls nor writes
    resetCycle();
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 2'd2, 5'd0, 2'd2, 1'b0);
    checkOutput("x0_stall", 64'(ifA.stall), 64'd0);
    checkOutput("x0_busy", 64'(ifA.busy), 64'd0);
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 5'd5, 2'd2, 5'd5, 2'd2, 1'b1);
    checkOutput("flush_stall", 64'(ifA.stall), 64'd0);
    checkOutput("flush_accept", 64'(ifA.accept), 64'd0);
    idleCycle();
    checkOutput("flush_busy", 64'(ifA.busy), 64'h20);

    // Reset lands in the first load-branch bubble
    resetCycle();
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 5'd0, 2'd1, 1'b0);
    checkOutput("mid_stall_pre", 64'(ifA.stall), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_stall_rst", 64'(ifA.stall), 64'd0);
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 2'd1, 5'd0, 2'd1, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_busy", 64'(ifA.busy), 64'd0);
    checkOutput("post_rst_count", 64'(ifA.stall_count), 64'd0);
    checkOutput("post_rst_stall", 64'(ifA.stall), 64'd0);

    // LOAD_LAT=7: lw x3 then beq x3 stalls seven cycles
    resetCycle();
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0);
      checkOutput($sformatf("lat7_stall%0d", i), 64'(ifC.stall), 64'd1);
    end
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0);
    checkOutput("lat7_accept", 64'(ifC.accept), 64'd1);
    idleCycle();
    checkOutput("lat7_stall_count", 64'(ifC.stall_count), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_hazard_scoreboard.md
Name: riscv_hazard_scoreboard

Overview:
Parametrised replacement for the fixed load-use, arith-branch and load-branch stall equations in the ID stage of the 5-stage core. It keeps a per-architectural-register countdown of cycles until each in-flight result reaches the forwarding network. For every operand it compares that countdown against the stage in which the consumer actually reads the operand (ID for branches, EX for ALU, MEM for store data). This handles any number of stall cycles, including the 2-cycle load-branch case.

Parameters:
REG_ADDR_LEN, 5, register address width; NUM_REGS = 2**REG_ADDR_LEN (derived, not overridable)
LAT_WIDTH, 3, width of each per-register countdown; must hold max(ALU_LAT, LOAD_LAT)
ALU_LAT, 1, countdown loaded for non-load producers; legal range 1..LOAD_LAT
LOAD_LAT, 2, countdown loaded for load producers; legal range ALU_LAT..2**LAT_WIDTH-1
CNT_WIDTH, 32, width of the stall performance counter

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  valid instruction present in IF/ID
issue_rd  in  REG_ADDR_LEN  destination register
issue_reg_write  in  1  instruction writes rd (REG_W)
issue_is_load  in  1  instruction is a load (M_R)
issue_rs1  in  REG_ADDR_LEN  source 1 address
issue_rs1_use  in  2  stage that consumes rs1: 0 none, 1 ID, 2 EX, 3 MEM
issue_rs2  in  REG_ADDR_LEN  source 2 address
issue_rs2_use  in  2  stage that consumes rs2, same encoding
flush  in  1  kill the instruction in IF/ID (taken branch redirect)
stall  out  1  hold PC and IF/ID, inject bubble into ID/EX (combinational)
accept  out  1  instruction leaves ID this cycle (combinational)
busy  out  NUM_REGS  bit r = (cnt[r] != 0), registered state
stall_count  out  CNT_WIDTH  number of cycles with stall=1 since reset

Behaviour:
- State: cnt[r], LAT_WIDTH bits, one per register r = 1..NUM_REGS-1. Register x0 has no storage; cnt[0] always reads 0.
- Hazard per operand k: haz_k = (use_k != 0) && (rs_k != 0) && (cnt[rs_k] >= use_k). The comparison zero-extends use_k to LAT_WIDTH.
- Resulting thresholds:
  - ID consumer stalls while cnt >= 1.
  - EX consumer stalls while cnt >= 2.
  - MEM consumer (store data) stalls while cnt >= 3.
- stall = !rst && issue_valid && !flush && (haz_1 || haz_2).
- accept = !rst && issue_valid && !flush && !stall.
- Counter update each cycle, evaluated in this order:
  1. Every nonzero cnt decrements by 1, saturating at 0. This happens regardless of stall, because producers downstream keep advancing.
  2. If accept && issue_reg_write && issue_rd != 0, then cnt[issue_rd] <= (issue_is_load ? LOAD_LAT : ALU_LAT). This overrides the decrement for that register.
- Hazard checks always use pre-update cnt values. An instruction whose rd equals its own rs (add x1,x1,x1) is checked against the older producer only.
- A stalled instruction re-evaluates every cycle with the decremented counts. The stall length for a single producer/consumer pair is max(0, LAT - use + 1).
- flush has priority over stall: stall=0 and accept=0, with no scoreboard write that cycle. Decrements still occur.
- issue_valid=0: stall=0, accept=0, decrements only.
- stall_count increments by 1 on every cycle with stall=1 and saturates at all-ones without wrapping.
- Reset (synchronous, including mid-stall):
  - On the rst edge: all cnt=0, stall_count=0, busy=0.
  - While rst=1: stall=0 and accept=0 combinationally.
  - The first cycle after rst deasserts sees an empty scoreboard.
- Latency: busy reflects an accepted producer one cycle after accept. stall and accept have zero-cycle latency from inputs.

Test Plan:
- Defaults, "add x5" (ALU) then next cycle "sub x6,x5,x5" (rs1/rs2 use=2) -> stall=0 both cycles; busy[5]=1 for exactly 1 cycle.
- "lw x5" then "add x7,x5,x1" (use=2) -> stall=1 for 1 cycle, accept on the 2nd cycle; stall_count=1.
- "lw x5" then "beq x5,x0" (use=1) -> stall=1 for 2 consecutive cycles, then accept; "add x5" then "beq" -> exactly 1 stall cycle.
- "lw x5" then "sw x5" (rs2 use=3, rs1=x2 use=2, x2 idle) -> no stall. Same sequence with LOAD_LAT=3 -> 1 stall cycle.
- Producer and consumer both use x0: "lw x0" then "add x1,x0,x0" -> stall=0, busy=0. Hazardous consumer with flush=1 -> stall=0, accept=0, no busy bit set.
- Assert rst during the 1st load-branch stall cycle -> next cycle busy=0, stall_count=0, stall=0. With LOAD_LAT=7, LAT_WIDTH=3, "lw x3" then "beq x3" -> exactly 7 stall cycles.
